misc_port_arbiter: RTL and testbench
====================================

Name: misc_port_arbiter

Overview:
- Shares the SDRAM controller's single edge-triggered misc port (misc_addr/misc_din/misc_rd/misc_we/misc_dout/misc_ready) among NREQ byte-wide requesters, e.g. floppy DMA, ROM loader and debugger.
- Arbitrates round-robin and sequences the controller's rd/we edge plus misc_ready low/high handshake.
- Returns read data with a one-cycle ack per requester.
- Guards against a stalled controller with a timeout.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 25, byte address width.
- TIMEOUT, 1023, maximum cycles in ISSUE+BUSY before abort.
- TW, 10, timeout counter width (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- init  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- req_we  in  NREQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- req_din  in  NREQ*8  packed write bytes.
- ack  out  NREQ  one-cycle completion strobe.
- rdata  out  8  read byte, valid while ack is high.
- err  out  1  high together with ack when the access timed out.
- grant  out  NREQ  one-hot owner of the current access; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- misc_addr  out  AW  address to the controller.
- misc_din  out  8  write data to the controller.
- misc_rd  out  1  read request level to the controller.
- misc_we  out  1  write request level to the controller.
- misc_dout  in  8  read data from the controller.
- misc_ready  in  1  controller status: drops after it detects a rd/we edge, rises on completion.

Behaviour:
- Reset (init high, asynchronous): state=IDLE; all outputs 0 (ack, rdata, err, grant, busy, misc_addr, misc_din, misc_rd, misc_we); rr_last=NREQ-1; timeout counter=0. Reset mid-access drops misc_rd/misc_we immediately and issues no ack.
- All outputs are registered.
- States: IDLE, ISSUE, BUSY, DONE, GAP.
- IDLE:
  - If any req bit is high, pick the first set index scanning rr_last+1, rr_last+2, ... modulo NREQ.
  - Register grant, misc_addr, misc_din, and misc_rd = ~req_we[i] or misc_we = req_we[i]; rr_last=i; counter=0; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE: hold misc_rd/misc_we. When misc_ready samples 0, go to BUSY. The counter increments every cycle.
- BUSY: when misc_ready samples 1:
  - If read, rdata<=misc_dout; if write, rdata unchanged.
  - Drop misc_rd/misc_we; ack[i]<=1; err<=0; go to DONE.
- Timeout: if the counter reaches TIMEOUT in ISSUE or BUSY:
  - Drop misc_rd/misc_we; ack[i]<=1; err<=1; rdata<=8'hFF; go to DONE.
  - Timeout has priority over a misc_ready event in the same cycle.
- DONE (one cycle, ack/err visible): ack<=0, err<=0, grant<=0; go to GAP.
- GAP (one cycle): misc_rd/misc_we remain low, so the controller's edge detector sees a low level before the next access. Go to IDLE.
- Requester rule:
  - Hold req, req_we, req_addr and req_din stable from assertion until ack.
  - Deassert req on the clock edge that ends the ack cycle, or keep it high to request another access, which is treated as new.
- req is sampled only in IDLE. Changes to req in any other state have no effect.
- Minimum access: 1 cycle IDLE + ISSUE + BUSY + DONE + GAP. The next grant is at the earliest 2 cycles after the ack cycle.
- Fairness: a continuously requesting client cannot win twice in a row while another client's req is high in IDLE.
- misc_ready high while in ISSUE is ignored, since only the low edge is awaited there. misc_ready low at IDLE entry is tolerated.

Test Plan:
- Single read: req[1]=1, req_we[1]=0, addr 0x000123; controller model drops ready 2 cycles later and raises it after 10 cycles with misc_dout=0x5A -> one misc_rd pulse with misc_addr=0x000123; ack[1] for exactly one cycle; rdata=0x5A; err=0; grant=3'b010 during the access.
- Single write: req[0]=1, req_we[0]=1, din=0xC3, addr 0x1FFFFFF -> misc_we high with misc_din=0xC3 and misc_addr=0x1FFFFFF; ack[0] pulses; misc_rd never asserts; rdata unchanged.
- Contention: all three reqs held continuously from reset -> grant order 0,1,2,0,1,2; every access separated by at least the GAP cycle with misc_rd low.
- Timeout: controller never drops misc_ready -> ack pulses exactly TIMEOUT cycles after ISSUE entry with err=1 and rdata=0xFF; next IDLE accepts new requests normally.
- Reset mid-access: assert init during BUSY -> misc_rd, grant and busy go low immediately (asynchronous); no ack; after release, first grant goes to requester 0.
- Back-to-back from one requester: req[2] held high with only client 2 active -> consecutive accesses with ack spacing of at least 4 cycles plus controller latency; misc_rd shows a low level between accesses.

Source files
------------

// File: rtl/misc_port_arbiter_if.sv
// Bundle of the requester-side and controller-side signals around the misc port arbiter.
interface misc_port_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 25
);
    // requester side
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*8-1:0]  req_din;
    logic [NREQ-1:0]    ack;
    logic [7:0]         rdata;
    logic               err;
    logic [NREQ-1:0]    grant;
    logic               busy;

    // SDRAM controller misc port side
    logic [AW-1:0]      misc_addr;
    logic [7:0]         misc_din;
    logic               misc_rd;
    logic               misc_we;
    logic [7:0]         misc_dout;
    logic               misc_ready;

    // Arbiter view: consumes requests and controller status, drives everything else.
    modport master (
        input  req, req_we, req_addr, req_din, misc_dout, misc_ready,
        output ack, rdata, err, grant, busy,
        output misc_addr, misc_din, misc_rd, misc_we
    );

    // Environment view: requesters plus controller.
    modport slave (
        output req, req_we, req_addr, req_din, misc_dout, misc_ready,
        input  ack, rdata, err, grant, busy,
        input  misc_addr, misc_din, misc_rd, misc_we
    );
endinterface

// File: rtl/misc_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's edge-triggered misc port
// among NREQ byte-wide requesters, with a stall timeout on each access.
module misc_port_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned AW      = 25,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TW      = 10
) (
    input  logic                clk,
    input  logic                init,
    misc_port_arbiter_if.master bus
);
    localparam int unsigned   IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE   = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE,
        S_GAP
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_last;
    logic [IW-1:0] owner;
    logic          is_write;
    logic [TW-1:0] cnt;

    logic [IW-1:0] pick_idx;
    logic          pick_ok;
    logic [AW-1:0] pick_addr;
    logic [7:0]    pick_din;
    logic          pick_we;
    logic          timed_out;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        pick_idx = rr_last;
        pick_ok  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!pick_ok && bus.req[IW'((32'(rr_last) + k) % NREQ)]) begin
                pick_ok  = 1'b1;
                pick_idx = IW'((32'(rr_last) + k) % NREQ);
            end
        end
    end

    // Select the winning requester's payload.
    always_comb begin
        pick_addr = '0;
        pick_din  = '0;
        pick_we   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_addr = bus.req_addr[i*AW +: AW];
                pick_din  = bus.req_din[i*8 +: 8];
                pick_we   = bus.req_we[i];
            end
        end
    end

    // The counter reaches TIMEOUT on the edge where it would step past TIMEOUT-1.
    assign timed_out = (cnt == TO_LAST);

    // Access sequencer: grant, issue edge, await ready low/high, ack, then a low gap.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state         <= S_IDLE;
            rr_last       <= IW'(NREQ - 1);
            owner         <= '0;
            is_write      <= 1'b0;
            cnt           <= '0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            bus.err       <= 1'b0;
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            bus.misc_addr <= '0;
            bus.misc_din  <= '0;
            bus.misc_rd   <= 1'b0;
            bus.misc_we   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_ok) begin
                        bus.grant     <= ONE << pick_idx;
                        owner         <= pick_idx;
                        rr_last       <= pick_idx;
                        is_write      <= pick_we;
                        bus.misc_addr <= pick_addr;
                        bus.misc_din  <= pick_din;
                        bus.misc_rd   <= ~pick_we;
                        bus.misc_we   <= pick_we;
                        bus.busy      <= 1'b1;
                        cnt           <= '0;
                        state         <= S_ISSUE;
                    end
                end

                S_ISSUE, S_BUSY: begin
                    cnt <= cnt + TW'(1);
                    if (timed_out) begin
                        // Stalled controller: abort with an error ack.
                        bus.misc_rd <= 1'b0;
                        bus.misc_we <= 1'b0;
                        bus.ack     <= ONE << owner;
                        bus.err     <= 1'b1;
                        bus.rdata   <= 8'hFF;
                        state       <= S_DONE;
                    end else if (state == S_ISSUE) begin
                        // Only the falling edge of ready is meaningful here.
                        if (!bus.misc_ready) begin
                            state <= S_BUSY;
                        end
                    end else if (bus.misc_ready) begin
                        if (!is_write) begin
                            bus.rdata <= bus.misc_dout;
                        end
                        bus.misc_rd <= 1'b0;
                        bus.misc_we <= 1'b0;
                        bus.ack     <= ONE << owner;
                        bus.err     <= 1'b0;
                        state       <= S_DONE;
                    end
                end

                S_DONE: begin
                    bus.ack   <= '0;
                    bus.err   <= 1'b0;
                    bus.grant <= '0;
                    state     <= S_GAP;
                end

                S_GAP: begin
                    // rd/we stay low one more cycle so the controller sees a fresh edge next time.
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_misc_port_arbiter.sv
// Scoreboard bench for misc_port_arbiter with a behavioural SDRAM misc-port model.
module tb_misc_port_arbiter;
    localparam int unsigned NREQ    = 3;
    localparam int unsigned AW      = 25;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned TW      = 10;

    logic clk  = 1'b0;
    logic init = 1'b0;

    always #5 clk = ~clk;

    misc_port_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

    misc_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk (clk),
        .init(init),
        .bus (bus)
    );

    typedef struct {
        bit         we;
        bit         to;
        logic [7:0] data;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t       exp_q [NREQ][$];
    logic [7:0] rmem [int unsigned];
    logic [7:0] cmem [int unsigned];

    logic [AW-1:0] cur_addr [NREQ];
    logic [7:0]    cur_din  [NREQ];
    bit            cur_we   [NREQ];

    int unsigned d1_min = 0, d1_max = 3, d2_min = 1, d2_max = 12;
    bit          ctrl_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input int unsigned a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Round-robin rule: first requester after the last winner, cyclically.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        int c;
        for (int k = 1; k <= int'(NREQ); k++) begin
            c = (last + k) % int'(NREQ);
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Controller model: sees a rd/we rising edge, drops ready, later raises it with data.
    int cst = 0;
    int unsigned ccnt = 0;
    bit prev_lvl = 1'b0;
    always @(negedge clk or posedge init) begin
        if (init) begin
            cst            = 0;
            ccnt           = 0;
            prev_lvl       = 1'b0;
            bus.misc_ready = 1'b1;
            bus.misc_dout  = 8'h00;
        end else begin
            if (cst == 0) begin
                if ((bus.misc_rd || bus.misc_we) && !prev_lvl && !ctrl_stall) begin
                    cst  = 1;
                    ccnt = $urandom_range(d1_max, d1_min);
                end
            end
            if (cst == 1) begin
                if (ccnt == 0) begin
                    bus.misc_ready = 1'b0;
                    if (bus.misc_we) cmem[32'(bus.misc_addr)] = bus.misc_din;
                    cst  = 2;
                    ccnt = $urandom_range(d2_max, d2_min);
                end else begin
                    ccnt--;
                end
            end else if (cst == 2) begin
                if (ccnt <= 1) begin
                    if (bus.misc_rd)
                        bus.misc_dout = cmem.exists(32'(bus.misc_addr)) ? cmem[32'(bus.misc_addr)]
                                                                       : dflt(32'(bus.misc_addr));
                    bus.misc_ready = 1'b1;
                    cst = 0;
                end else begin
                    ccnt--;
                end
            end
            prev_lvl = bus.misc_rd || bus.misc_we;
        end
    end

    // Present one access on requester i and record its expected response.
    task automatic issue(input int i, input bit we, input logic [AW-1:0] a,
                         input logic [7:0] d, input bit to);
        exp_t e;
        cur_we[i]   = we;
        cur_addr[i] = a;
        cur_din[i]  = d;
        bus.req_we[i]              = we;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_din[i*8 +: 8]      = d;
        bus.req[i]                 = 1'b1;
        e.we = we;
        e.to = to;
        if (to) begin
            e.data = 8'hFF;
        end else if (we) begin
            rmem[32'(a)] = d;
            e.data = d;
        end else begin
            e.data = rmem.exists(32'(a)) ? rmem[32'(a)] : dflt(32'(a));
        end
        exp_q[i].push_back(e);
    endtask

    task automatic wait_ack(input int i, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.ack[i] && k < budget);
        if (!bus.ack[i]) begin
            checks++;
            errors++;
            $display("FAIL ack_wait_client%0d: no ack within %0d cycles", i, budget);
        end
    endtask

    task automatic run_client(input int i, input int n, input int max_gap);
        int unsigned a;
        int gap;
        for (int t = 0; t < n; t++) begin
            a = ($urandom_range(15, 0) << 2) | 32'(i);
            issue(i, 1'($urandom_range(1, 0)), AW'(a), 8'($urandom), 1'b0);
            wait_ack(i, int'(TIMEOUT) + 100);
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0) begin
                bus.req[i] = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.req[i] = 1'b0;
    endtask

    // Monitor: checks issue, hold, ack and fairness against the scoreboard.
    logic [NREQ-1:0] prev_grant = '0, prev_ack = '0;
    bit         prev_lvl_m = 1'b0;
    bit         in_acc = 1'b0;
    int         owner_m = 0, rr_m = NREQ - 1, issue_cyc = 0, last_ack_cyc = -1;
    logic [7:0] last_rd = 8'h00;
    initial begin
        int   w;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (init) begin
                prev_grant   = '0;
                prev_ack     = '0;
                prev_lvl_m   = 1'b0;
                in_acc       = 1'b0;
                rr_m         = NREQ - 1;
                last_ack_cyc = -1;
                last_rd      = 8'h00;
            end else begin
                if (prev_ack != '0) chk("ack_single_cycle", 32'(bus.ack), 32'(0));
                if (bus.busy) chk("rd_we_exclusive", 32'(bus.misc_rd & bus.misc_we), 32'(0));

                if (prev_grant == '0 && bus.grant != '0) begin
                    w = rr_pick(bus.req, rr_m);
                    chk("grant_rr", 32'(bus.grant), (w < 0) ? 32'(0) : (32'(1) << w));
                    chk("gap_low_before_issue", 32'(prev_lvl_m), 32'(0));
                    if (last_ack_cyc >= 0)
                        chk("ack_to_grant_spacing", 32'(cyc - last_ack_cyc >= 3), 32'(1));
                    if (w >= 0) begin
                        chk("issue_addr", 32'(bus.misc_addr), 32'(cur_addr[w]));
                        chk("issue_rd", 32'(bus.misc_rd), 32'(!cur_we[w]));
                        chk("issue_we", 32'(bus.misc_we), 32'(cur_we[w]));
                        if (cur_we[w]) chk("issue_din", 32'(bus.misc_din), 32'(cur_din[w]));
                        rr_m      = w;
                        owner_m   = w;
                        in_acc    = 1'b1;
                        issue_cyc = cyc;
                    end
                end else if (in_acc && bus.ack == '0) begin
                    chk("hold_rd", 32'(bus.misc_rd), 32'(!cur_we[owner_m]));
                    chk("hold_we", 32'(bus.misc_we), 32'(cur_we[owner_m]));
                    chk("hold_busy", 32'(bus.busy), 32'(1));
                end

                if (bus.ack != '0) begin
                    chk("ack_owner", 32'(bus.ack), in_acc ? (32'(1) << owner_m) : 32'(0));
                    if (in_acc) begin
                        if (exp_q[owner_m].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ack: client %0d acked with nothing outstanding", owner_m);
                        end else begin
                            e = exp_q[owner_m].pop_front();
                            chk("ack_err", 32'(bus.err), 32'(e.to));
                            if (e.we && !e.to) begin
                                chk("write_rdata_unchanged", 32'(bus.rdata), 32'(last_rd));
                            end else begin
                                chk("ack_rdata", 32'(bus.rdata), 32'(e.data));
                                last_rd = e.data;
                            end
                            if (e.to) chk("timeout_latency", 32'(cyc - issue_cyc), 32'(TIMEOUT));
                            else      chk("latency_bound", 32'(cyc - issue_cyc < int'(TIMEOUT)), 32'(1));
                            chk("drop_at_ack", 32'(bus.misc_rd | bus.misc_we), 32'(0));
                        end
                    end
                    in_acc       = 1'b0;
                    last_ack_cyc = cyc;
                end

                prev_grant = bus.grant;
                prev_ack   = bus.ack;
                prev_lvl_m = bus.misc_rd | bus.misc_we;
            end
        end
    end

    // Directed and randomized phases.
    initial begin
        int k;
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_addr = '0;
        bus.req_din  = '0;
        #1 init = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack",   32'(bus.ack), 32'(0));
        chk("rst_rdata", 32'(bus.rdata), 32'(0));
        chk("rst_err",   32'(bus.err), 32'(0));
        chk("rst_grant", 32'(bus.grant), 32'(0));
        chk("rst_busy",  32'(bus.busy), 32'(0));
        chk("rst_addr",  32'(bus.misc_addr), 32'(0));
        chk("rst_din",   32'(bus.misc_din), 32'(0));
        chk("rst_rdwe",  32'({bus.misc_rd, bus.misc_we}), 32'(0));
        init = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_req", 32'(bus.busy), 32'(0));

        // single read on requester 1
        rmem[32'h123] = 8'h5A;
        cmem[32'h123] = 8'h5A;
        d1_min = 2; d1_max = 2; d2_min = 10; d2_max = 10;
        issue(1, 1'b0, 25'h000123, 8'h00, 1'b0);
        wait_ack(1, 100);
        chk("read_grant", 32'(bus.grant), 32'(3'b010));
        chk("read_data", 32'(bus.rdata), 32'(8'h5A));
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);

        // single write on requester 0
        issue(0, 1'b1, 25'h1FFFFFF, 8'hC3, 1'b0);
        wait_ack(0, 100);
        chk("write_keeps_rdata", 32'(bus.rdata), 32'(8'h5A));
        chk("write_reached_ctrl", 32'(cmem.exists(32'h1FFFFFF) ? cmem[32'h1FFFFFF] : 8'h00), 32'(8'hC3));
        bus.req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // contention: all requesters held continuously
        d1_min = 0; d1_max = 3; d2_min = 1; d2_max = 12;
        fork
            run_client(0, 6, 0);
            run_client(1, 6, 0);
            run_client(2, 6, 0);
        join
        repeat (3) @(negedge clk);

        // random traffic with idle gaps
        fork
            run_client(0, int'($urandom_range(10, 4)), 4);
            run_client(1, int'($urandom_range(10, 4)), 4);
            run_client(2, int'($urandom_range(10, 4)), 4);
        join
        repeat (3) @(negedge clk);

        // timeout: controller never drops ready
        ctrl_stall = 1'b1;
        issue(2, 1'b0, 25'h000042, 8'h00, 1'b1);
        wait_ack(2, int'(TIMEOUT) + 100);
        chk("timeout_err", 32'(bus.err), 32'(1));
        chk("timeout_rdata", 32'(bus.rdata), 32'(8'hFF));
        bus.req[2] = 1'b0;
        ctrl_stall = 1'b0;
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 25'h000050, 8'h00, 1'b0);
        wait_ack(0, 100);
        chk("after_timeout_err", 32'(bus.err), 32'(0));
        bus.req[0] = 1'b0;
        repeat (3) @(negedge clk);

        // back-to-back from a single requester
        run_client(2, 5, 0);
        repeat (3) @(negedge clk);

        // reset in the middle of an access
        d1_min = 1; d1_max = 1; d2_min = 40; d2_max = 40;
        issue(1, 1'b0, 25'h000061, 8'h00, 1'b0);
        exp_q[1].delete();
        k = 0;
        while (!(bus.busy && !bus.misc_ready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reached_busy", 32'(bus.busy && !bus.misc_ready), 32'(1));
        repeat (3) @(negedge clk);
        #2 init = 1'b1;
        #1;
        chk("async_rst_rd",    32'(bus.misc_rd), 32'(0));
        chk("async_rst_grant", 32'(bus.grant), 32'(0));
        chk("async_rst_busy",  32'(bus.busy), 32'(0));
        chk("async_rst_ack",   32'(bus.ack), 32'(0));
        bus.req = '0;
        repeat (2) @(negedge clk);
        init = 1'b0;
        d1_min = 0; d1_max = 3; d2_min = 1; d2_max = 12;
        @(negedge clk);
        fork
            run_client(0, 1, 0);
            run_client(1, 1, 0);
            run_client(2, 1, 0);
        join_none
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.grant == '0 && k < 20);
        chk("first_grant_after_reset", 32'(bus.grant), 32'(3'b001));
        wait fork;
        repeat (5) @(negedge clk);

        for (int i = 0; i < int'(NREQ); i++) chk("queue_drained", 32'(exp_q[i].size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
